traffic_light_ctrl: RTL
=======================

// Module: traffic_light_ctrl
// PURPOSE
//   Controller that shares one intersection between a main road and a side road.
//   Main road rests on green. A side-road car sensor requests service.
//   Sequences both light sets through yellow and all-red phases with cycle-exact timing.
//   Emergency input forces both roads to red.
//   Sits above the light drivers; the state code is exported for the bench and monitors.
// PARAMETERS
//   T_MIN_GREEN   4  minimum main-green cycles before a side request is honoured
//   T_YELLOW      2  cycles in each yellow phase
//   T_ALLRED      1  minimum cycles in each all-red phase
//   T_SIDE_GREEN  3  fixed side-green duration in cycles
//   TW            4  timer width; every T_* must be in 1..2**TW-1
// PORTS
//   clk         in   1  clock, all state changes on rising edge
//   rst         in   1  synchronous reset, active-high
//   car_side    in   1  side-road car present (level, sampled each edge, not latched)
//   emerg       in   1  emergency request (level): drive all lights to red and hold
//   main_light  out  3  {green,yellow,red} one-hot: 100 G, 010 Y, 001 R
//   side_light  out  3  same encoding as main_light
//   state       out  3  current state code
// BEHAVIOUR
//   States and codes: MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5; codes 6,7 are illegal.
//   Moore machine: lights decode combinationally from the state register, zero extra latency.
//   Light decode:
//     MG: main=100, side=001
//     MY: main=010, side=001
//     AR1, AR2, illegal codes: both 001
//     SG: main=001, side=100
//     SY: main=001, side=010
//   Timer: down-counter, loaded with D-1 on entry to a state of duration D.
//     Decrements each cycle; saturates at 0; done = (timer==0).
//   Reset (rst=1 at an edge): state=MG, timer=T_MIN_GREEN-1. Outputs next cycle: main=100, side=001.
//   rst overrides every input. Outputs are undefined (X) before the first reset.
//   Transitions, evaluated per edge with rst=0 (emerg has priority over car_side):
//     MG : emerg -> MY (min-green ignored); done && car_side -> MY; else stay
//     MY : done -> AR1                        (lasts exactly T_YELLOW)
//     AR1: done && !emerg -> SG; else stay     (held while emerg=1)
//     SG : emerg || done -> SY                 (T_SIDE_GREEN, cut short by emerg)
//     SY : done -> AR2                        (lasts exactly T_YELLOW; emerg does not shorten it)
//     AR2: done && !emerg -> MG; else stay     (held while emerg=1)
//     illegal code -> AR2, timer loaded T_ALLRED-1 (safe recovery)
//   With no emerg, a full side-service round is 13 cycles: MG4 + MY2 + AR1 1 + SG3 + SY2 + AR2 1.
//   In MG, once done, car_side=1 in any cycle moves to MY at the next edge.
//   A car_side pulse while MG is not yet done is lost; it is not remembered.
//   Safety invariant, always: main_light and side_light are never both non-red.
//   Safety invariant, always: each light vector is one-hot.
// STRUCTURE
//   Package traffic_pkg holds:
//     state localparams MG..AR2
//     light codes L_GREEN=3'b100, L_YELLOW=3'b010, L_RED=3'b001
//   Sub-module tl_timer #(TW): ports clk, rst, load, load_val[TW-1:0], done. Performs the saturating down-count.
//   Top level contains: next-state logic, the timer load on each state change, and the light decode.
// TESTING
//   Defaults used throughout; cycle numbers count from the first edge after rst falls.
//   T1 Idle: rst 1 cycle, then car_side=0, emerg=0 for 20 cycles -> state=0, main=100, side=001 throughout.
//   T2 Early pulse: car_side=1 only in cycle 1 -> ignored; state stays MG for 20 cycles.
//   T3 Held car: car_side=1 from reset -> state sequence 0000 11 2 333 44 5 then 0000 repeating.
//      Period is 13 cycles; side=100 exactly in the 3 SG cycles.
//   T4 Emergency in SG: emerg=1 in SG cycle 1 for 6 cycles -> SY next edge, SY 2 cycles, AR2 held.
//      MG returns 1 cycle after emerg falls; both lights are 001 while in AR2.
//   T5 Emergency in MG at cycle 1 -> MY next edge despite min-green; AR1 held while emerg=1; then SG.
//   T6 Reset mid-operation: rst=1 during SY -> next cycle state=0, main=100.
//      MG then lasts T_MIN_GREEN cycles before honouring car_side.
//      Invariant monitor runs on every cycle of T1..T6.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state codes, light codes and light decode for the intersection controller.
package traffic_pkg;

  localparam logic [2:0] MG  = 3'd0;
  localparam logic [2:0] MY  = 3'd1;
  localparam logic [2:0] AR1 = 3'd2;
  localparam logic [2:0] SG  = 3'd3;
  localparam logic [2:0] SY  = 3'd4;
  localparam logic [2:0] AR2 = 3'd5;

  localparam logic [2:0] L_GREEN  = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_RED    = 3'b001;

  typedef enum logic [2:0] {
    ST_MG  = MG,
    ST_MY  = MY,
    ST_AR1 = AR1,
    ST_SG  = SG,
    ST_SY  = SY,
    ST_AR2 = AR2
  } state_t;

  // Returns {main, side}; anything that is not a known state shows all red.
  function automatic logic [5:0] light_decode(input logic [2:0] s);
    case (s)
      MG:      return {L_GREEN,  L_RED};
      MY:      return {L_YELLOW, L_RED};
      SG:      return {L_RED,    L_GREEN};
      SY:      return {L_RED,    L_YELLOW};
      default: return {L_RED,    L_RED};
    endcase
  endfunction

endpackage

// File: rtl/tl_timer.sv
// Saturating down-counter used as the phase timer; done while the count sits at zero.
module tl_timer #(
  parameter int unsigned     TW      = 4,
  parameter logic [TW-1:0]   RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Main/side road intersection sequencer: Moore FSM with one shared phase timer.
// State | meaning
// MG    | main green, side red (rest state, min-green enforced)
// MY    | main yellow
// AR1   | all red before side service (held during emergency)
// SG    | side green (fixed length, cut short by emergency)
// SY    | side yellow
// AR2   | all red before returning to main (held during emergency)
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned T_MIN_GREEN  = 4,
  parameter int unsigned T_YELLOW     = 2,
  parameter int unsigned T_ALLRED     = 1,
  parameter int unsigned T_SIDE_GREEN = 3,
  parameter int unsigned TW           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_side,
  input  logic       emerg,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [2:0] state
);

  state_t        state_q, state_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic          tmr_done;

  // Timer preload for a phase of duration D is D-1 so done rises on its last cycle.
  function automatic logic [TW-1:0] load_for(input state_t s);
    case (s)
      ST_MG:        return TW'(T_MIN_GREEN - 1);
      ST_MY, ST_SY: return TW'(T_YELLOW - 1);
      ST_SG:        return TW'(T_SIDE_GREEN - 1);
      default:      return TW'(T_ALLRED - 1);
    endcase
  endfunction

  tl_timer #(
    .TW      (TW),
    .RST_VAL (TW'(T_MIN_GREEN - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MG: begin
        if (emerg || (tmr_done && car_side)) state_d = ST_MY;
      end
      ST_MY: begin
        if (tmr_done) state_d = ST_AR1;
      end
      ST_AR1: begin
        if (tmr_done && !emerg) state_d = ST_SG;
      end
      ST_SG: begin
        if (emerg || tmr_done) state_d = ST_SY;
      end
      ST_SY: begin
        if (tmr_done) state_d = ST_AR2;
      end
      ST_AR2: begin
        if (tmr_done && !emerg) state_d = ST_MG;
      end
      default: state_d = ST_AR2;
    endcase
  end

  // Every phase change restarts the timer; staying in a phase lets it run down and saturate.
  always_comb begin
    tmr_load     = (state_d != state_q);
    tmr_load_val = load_for(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_MG;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    {main_light, side_light} = light_decode(state_q);
  end

  assign state = state_q;

endmodule
